// File: rtl/decimal_entry_encoder_pkg.sv
// Shared constants and types for the keypad decimal entry path.
// Holds the FSM state encoding, BCD adjust constants and two's complement range limits.
package decimal_entry_encoder_pkg;

    localparam int NUM_DIGITS_DEF = 3;
    localparam int WIDTH_DEF      = 8;
    localparam int MAG_W_DEF      = 10;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] DD_ADJ    = 4'd3;
    localparam logic [3:0] DD_THRESH = 4'd8;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CONVERT = 2'd1,
        ST_CHECK   = 2'd2
    } state_e;

    function automatic int pos_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int neg_max(input int w);
        return (1 << (w - 1));
    endfunction

    localparam int POS_MAX = pos_max(WIDTH_DEF);
    localparam int NEG_MAX = neg_max(WIDTH_DEF);

endpackage

// File: rtl/decimal_entry_encoder_if.sv
// Keypad-side bus: digit/sign/enter/clear strobes in, live BCD echo and converted result out.
interface decimal_entry_encoder_if #(
    parameter int NUM_DIGITS = 3,
    parameter int WIDTH      = 8
);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic                    digit_valid;
    logic [3:0]              digit;
    logic                    sign_toggle;
    logic                    enter;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] entry_digits;
    logic [CNT_W-1:0]        entry_count;
    logic                    entry_sign;
    logic                    busy;
    logic                    result_valid;
    logic [WIDTH-1:0]        value;
    logic                    error;

    modport master (
        output digit_valid, digit, sign_toggle, enter, clear,
        input  entry_digits, entry_count, entry_sign, busy, result_valid, value, error
    );

    modport slave (
        input  digit_valid, digit, sign_toggle, enter, clear,
        output entry_digits, entry_count, entry_sign, busy, result_valid, value, error
    );

endinterface

// File: rtl/decimal_entry_encoder_bcd_to_binary_serial.sv
// Serial reverse double-dabble: one shift/adjust step per cycle, 4*NUM_DIGITS steps total.
module bcd_to_binary_serial
    import decimal_entry_encoder_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int MAG_W      = MAG_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [MAG_W-1:0]        mag_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BCD_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BCD_W - 1);

    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;

    logic [BCD_W-1:0] bcd_sh;
    logic [BCD_W-1:0] bin_sh;
    logic [BCD_W-1:0] bcd_adj;

    assign bcd_sh = {1'b0, bcd_q[BCD_W-1:1]};
    assign bin_sh = {bcd_q[0], bin_q[BCD_W-1:1]};

    // After the shift, any digit that picked up the carried-in half (>=8) gets 3 removed.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_sh[4*gi +: 4] >= DD_THRESH)
                                    ? (bcd_sh[4*gi +: 4] - DD_ADJ)
                                    : bcd_sh[4*gi +: 4];
    end

    always_comb begin
        bcd_d = bcd_q;
        bin_d = bin_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (abort_i) begin
            run_d = 1'b0;
        end else if (start_i) begin
            bcd_d = bcd_i;
            bin_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = bcd_adj;
            bin_d = bin_sh;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign busy_o = run_q;
    assign done_o = run_q && (cnt_q == LAST_STEP);
    assign mag_o  = MAG_W'(bin_q);

endmodule

// File: rtl/decimal_entry_encoder.sv
// Signed decimal keypad entry: BCD buffer with live echo, serial conversion on enter,
// range check and two's complement result with a one-cycle valid strobe.
module decimal_entry_encoder
    import decimal_entry_encoder_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int MAG_W      = MAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decimal_entry_encoder_if.slave bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [MAG_W-1:0] POS_LIM  = MAG_W'(pos_max(WIDTH));
    localparam logic [MAG_W-1:0] NEG_LIM  = MAG_W'(neg_max(WIDTH));
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);

    state_e           state_q, state_d;
    logic [BCD_W-1:0] digits_q, digits_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sign_q, sign_d;
    logic             fresh_q, fresh_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             error_q, error_d;

    logic             conv_start;
    logic             conv_abort;
    logic             conv_busy;
    logic             conv_done;
    logic [MAG_W-1:0] conv_mag;

    logic             digit_ok;
    logic             range_fail;
    logic [WIDTH-1:0] mag_w;
    logic [WIDTH-1:0] signed_val;
    logic             check_fire;
    logic [BCD_W-1:0] digits_base;
    logic [CNT_W-1:0] count_base;
    logic             sign_base;

    bcd_to_binary_serial #(
        .NUM_DIGITS (NUM_DIGITS),
        .MAG_W      (MAG_W)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .abort_i (conv_abort),
        .bcd_i   (digits_q),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .mag_o   (conv_mag)
    );

    assign digit_ok   = bus.digit_valid && (bus.digit <= BCD_MAX);
    assign range_fail = sign_q ? (conv_mag > NEG_LIM) : (conv_mag > POS_LIM);
    assign mag_w      = conv_mag[WIDTH-1:0];
    // -128 wraps onto itself and -0 onto 0, which is exactly what the range allows.
    assign signed_val = sign_q ? (~mag_w + 1'b1) : mag_w;

    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        count_d     = count_q;
        sign_d      = sign_q;
        fresh_d     = fresh_q;
        value_d     = value_q;
        error_d     = error_q;
        conv_start  = 1'b0;
        conv_abort  = 1'b0;
        check_fire  = 1'b0;
        digits_base = digits_q;
        count_base  = count_q;
        sign_base   = sign_q;

        case (state_q)
            ST_ENTRY: begin
                if (bus.clear) begin
                    digits_d = '0;
                    count_d  = '0;
                    sign_d   = 1'b0;
                    fresh_d  = 1'b0;
                end else if (bus.enter) begin
                    conv_start = 1'b1;
                    state_d    = ST_CONVERT;
                end else begin
                    // A shown result stays on display until the next edit starts a new entry.
                    if (fresh_q && (digit_ok || bus.sign_toggle)) begin
                        digits_base = '0;
                        count_base  = '0;
                        sign_base   = 1'b0;
                        fresh_d     = 1'b0;
                    end
                    digits_d = digits_base;
                    count_d  = count_base;
                    sign_d   = sign_base;
                    if (digit_ok && (count_base < CNT_FULL)) begin
                        digits_d = {digits_base[BCD_W-5:0], bus.digit};
                        count_d  = count_base + 1'b1;
                    end
                    if (bus.sign_toggle) begin
                        sign_d = ~sign_base;
                    end
                end
            end
            ST_CONVERT: begin
                if (bus.clear) begin
                    conv_abort = 1'b1;
                    state_d    = ST_ENTRY;
                    digits_d   = '0;
                    count_d    = '0;
                    sign_d     = 1'b0;
                    fresh_d    = 1'b0;
                end else if (conv_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_ENTRY;
                if (bus.clear) begin
                    digits_d = '0;
                    count_d  = '0;
                    sign_d   = 1'b0;
                    fresh_d  = 1'b0;
                end else begin
                    check_fire = 1'b1;
                    fresh_d    = 1'b1;
                    error_d    = range_fail;
                    if (!range_fail) begin
                        value_d = signed_val;
                    end
                end
            end
            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_ENTRY;
            digits_q <= '0;
            count_q  <= '0;
            sign_q   <= 1'b0;
            fresh_q  <= 1'b0;
            value_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            fresh_q  <= fresh_d;
            value_q  <= value_d;
            error_q  <= error_d;
        end
    end

    // value/error present the check outcome in the same cycle as result_valid.
    assign bus.entry_digits = digits_q;
    assign bus.entry_count  = count_q;
    assign bus.entry_sign   = sign_q;
    assign bus.busy         = conv_busy || (state_q == ST_CHECK);
    assign bus.result_valid = check_fire;
    assign bus.value        = value_d;
    assign bus.error        = error_d;

endmodule

// File: tb/tb_decimal_entry_encoder.sv
// Directed bench for decimal_entry_encoder: hand-computed entries, latency and boundary checks.
module tb_decimal_entry_encoder;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    decimal_entry_encoder_if #(.NUM_DIGITS(3), .WIDTH(8)) ent_if ();

    decimal_entry_encoder #(
        .NUM_DIGITS (3),
        .WIDTH      (8),
        .MAG_W      (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ent_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic [3:0] d, input logic st,
                         input logic en, input logic cl);
        ent_if.digit_valid = dv;
        ent_if.digit       = d;
        ent_if.sign_toggle = st;
        ent_if.enter       = en;
        ent_if.clear       = cl;
        tick();
        ent_if.digit_valid = 1'b0;
        ent_if.digit       = 4'd0;
        ent_if.sign_toggle = 1'b0;
        ent_if.enter       = 1'b0;
        ent_if.clear       = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sign_key();
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_key();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Called just after the enter edge; waits for result_valid and checks its value/error.
    task automatic await_result(input string tag, input int exp_value, input int exp_error);
        int n;
        n = 1;
        check_eq({tag, " busy_after_enter"}, int'(ent_if.busy), 1);
        while (!ent_if.result_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, " latency"}, n, 13);
        check_eq({tag, " value"}, int'(ent_if.value), exp_value);
        check_eq({tag, " error"}, int'(ent_if.error), exp_error);
        tick();
        check_eq({tag, " valid_one_cycle"}, int'(ent_if.result_valid), 0);
        check_eq({tag, " busy_done"}, int'(ent_if.busy), 0);
    endtask

    task automatic enter_and_await(input string tag, input int exp_value, input int exp_error);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        await_result(tag, exp_value, exp_error);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " digits"}, int'(ent_if.entry_digits), 0);
        check_eq({tag, " count"}, int'(ent_if.entry_count), 0);
        check_eq({tag, " sign"}, int'(ent_if.entry_sign), 0);
        check_eq({tag, " busy"}, int'(ent_if.busy), 0);
        check_eq({tag, " valid"}, int'(ent_if.result_valid), 0);
        check_eq({tag, " value"}, int'(ent_if.value), 0);
        check_eq({tag, " error"}, int'(ent_if.error), 0);
    endtask

    initial begin
        int seen_valid;
        n_checks = 0;
        n_fail   = 0;
        ent_if.digit_valid = 1'b0;
        ent_if.digit       = 4'd0;
        ent_if.sign_toggle = 1'b0;
        ent_if.enter       = 1'b0;
        ent_if.clear       = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_outputs("reset");

        // +127: largest positive value.
        key(4'd1); key(4'd2); key(4'd7);
        check_eq("p127 digits", int'(ent_if.entry_digits), 'h127);
        check_eq("p127 count", int'(ent_if.entry_count), 3);
        enter_and_await("p127", 'h7F, 0);

        // -128: largest negative magnitude; sign toggle on fresh clears the old entry.
        sign_key();
        check_eq("n128 fresh_digits", int'(ent_if.entry_digits), 0);
        check_eq("n128 sign", int'(ent_if.entry_sign), 1);
        key(4'd1); key(4'd2); key(4'd8);
        enter_and_await("n128", 'h80, 0);
        check_eq("n128 sign_kept", int'(ent_if.entry_sign), 1);

        // +128 overflows; value keeps 0x80. First digit after a result resets the sign.
        key(4'd1);
        check_eq("p128 sign_reset", int'(ent_if.entry_sign), 0);
        key(4'd2); key(4'd8);
        enter_and_await("p128", 'h80, 1);

        // -999 overflows too.
        sign_key(); key(4'd9); key(4'd9); key(4'd9);
        check_eq("n999 digits", int'(ent_if.entry_digits), 'h999);
        enter_and_await("n999", 'h80, 1);

        // Full buffer drops the fourth digit; out-of-range digit codes are ignored.
        key(4'd4); key(4'd5); key(4'd6); key(4'd7);
        check_eq("full count", int'(ent_if.entry_count), 3);
        check_eq("full digits", int'(ent_if.entry_digits), 'h456);
        clear_key();
        check_eq("clear count", int'(ent_if.entry_count), 0);
        key(4'd12);
        check_eq("bad_digit count", int'(ent_if.entry_count), 0);
        enter_and_await("empty", 0, 0);

        // Clear five cycles into CONVERT aborts silently.
        key(4'd5); key(4'd5);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        check_eq("abort busy_before", int'(ent_if.busy), 1);
        clear_key();
        check_eq("abort busy", int'(ent_if.busy), 0);
        check_eq("abort digits", int'(ent_if.entry_digits), 0);
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (ent_if.result_valid) seen_valid = 1;
            tick();
        end
        check_eq("abort no_valid", seen_valid, 0);
        check_eq("abort value_held", int'(ent_if.value), 0);

        // enter together with a digit: the digit is dropped, 42 converted.
        key(4'd4); key(4'd2);
        drive(1'b1, 4'd9, 1'b0, 1'b1, 1'b0);
        check_eq("enter_digit digits", int'(ent_if.entry_digits), 'h042);
        await_result("enter_digit", 'h2A, 0);

        // -5, then a fresh digit restarts the buffer positive.
        sign_key(); key(4'd5);
        enter_and_await("n5", 'hFB, 0);
        key(4'd3);
        check_eq("fresh digits", int'(ent_if.entry_digits), 'h003);
        check_eq("fresh sign", int'(ent_if.entry_sign), 0);
        check_eq("fresh count", int'(ent_if.entry_count), 1);

        // -0 gives 0 without error.
        clear_key(); sign_key();
        enter_and_await("neg_zero", 0, 0);

        // Reset in the middle of a conversion.
        sign_key(); key(4'd7);
        enter_and_await("n7", 'hF9, 0);
        key(4'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
